// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state type and default sizing for the dispense sequencer
package disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DISPENSE,
    DONE
  } disp_state_t;

  localparam int DISP_N_CH  = 4;
  localparam int DISP_DOSE_W = 3;
  localparam int DISP_TICKS = 2;

endpackage

// File: rtl/dose_timer.sv
// rtl/dose_timer.sv - counts clocks within one dose unit and flags its terminal tick
module dose_timer #(
  parameter int TICKS_PER_DOSE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic dose_tick
);

  localparam int TW = $clog2(TICKS_PER_DOSE + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_DOSE - 1);

  logic [TW-1:0] r_tick;
  logic          w_terminal;

  assign w_terminal = (r_tick == LAST_TICK);
  assign dose_tick  = run && w_terminal;

  // Tick counter: cleared outside a dose, holds while not running, restarts after the terminal tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
    end else if (clear) begin
      r_tick <= '0;
    end else if (run) begin
      r_tick <= w_terminal ? '0 : r_tick + 1'b1;
    end
  end

endmodule

// File: rtl/disp_sequencer.sv
// rtl/disp_sequencer.sv - multi-channel ingredient dose sequencer (optional DISP_PAUSE_EN adds pause input)
module disp_sequencer
  import disp_pkg::*;
#(
  parameter int N_CH           = DISP_N_CH,
  parameter int DOSE_W         = DISP_DOSE_W,
  parameter int TICKS_PER_DOSE = DISP_TICKS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_CH*DOSE_W-1:0]    doses,
  input  logic                      abort,
`ifdef DISP_PAUSE_EN
  input  logic                      pause,
`endif
  output logic                      busy,
  output logic [N_CH-1:0]           led,
  output logic [$clog2(N_CH)-1:0]   ch_idx,
  output logic [DOSE_W-1:0]         dose_cnt,
  output logic                      done,
  output logic                      aborted
);

  localparam int CW = $clog2(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);
  localparam logic [N_CH-1:0] LED_CH0 = {{(N_CH-1){1'b0}}, 1'b1};

  disp_state_t              r_state, w_state_n;
  logic [N_CH*DOSE_W-1:0]   r_doses, w_doses_n;
  logic [CW-1:0]            r_ch, w_ch_n;
  logic [DOSE_W-1:0]        r_cnt, w_cnt_n;
  logic [DOSE_W-1:0]        w_cur_dose, w_cnt_inc;
  logic [N_CH-1:0]          r_led, w_led_n;
  logic                     r_busy, r_done, r_aborted, w_aborted_n;
  logic                     w_pause, w_run, w_clear, w_dose_tick;
  logic                     w_last_ch;

`ifdef DISP_PAUSE_EN
  assign w_pause = pause && (r_state == DISPENSE);
`else
  assign w_pause = 1'b0;
`endif

  assign w_run      = (r_state == DISPENSE) && !w_pause;
  assign w_clear    = (r_state != DISPENSE);
  assign w_cur_dose = r_doses[r_ch*DOSE_W +: DOSE_W];
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last_ch  = (r_ch == LAST_CH);

  dose_timer #(
    .TICKS_PER_DOSE(TICKS_PER_DOSE)
  ) u_dose_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .run      (w_run),
    .dose_tick(w_dose_tick)
  );

  // Next-state logic; abort is checked first so it wins over any completion in the same cycle.
  always_comb begin
    w_state_n   = r_state;
    w_doses_n   = r_doses;
    w_ch_n      = r_ch;
    w_cnt_n     = r_cnt;
    w_aborted_n = 1'b0;
    w_led_n     = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_doses_n = doses;
          w_ch_n    = '0;
          w_cnt_n   = '0;
          w_state_n = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          w_state_n   = IDLE;
          w_aborted_n = 1'b1;
        end else if (w_cur_dose != '0) begin
          w_cnt_n   = '0;
          w_state_n = DISPENSE;
        end else if (w_last_ch) begin
          w_state_n = DONE;
        end else begin
          w_ch_n = r_ch + 1'b1;
        end
      end
      DISPENSE: begin
        if (abort) begin
          w_state_n   = IDLE;
          w_aborted_n = 1'b1;
        end else if (w_dose_tick) begin
          if (w_cnt_inc == w_cur_dose) begin
            if (w_last_ch) begin
              w_cnt_n   = w_cnt_inc;
              w_state_n = DONE;
            end else begin
              w_cnt_n   = '0;
              w_ch_n    = r_ch + 1'b1;
              w_state_n = SCAN;
            end
          end else begin
            w_cnt_n = w_cnt_inc;
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
    if ((w_state_n == DISPENSE) && !w_pause) begin
      w_led_n = LED_CH0 << w_ch_n;
    end
  end

  // State and registered outputs; reset clears everything immediately without any pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_doses   <= '0;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_doses   <= w_doses_n;
      r_ch      <= w_ch_n;
      r_cnt     <= w_cnt_n;
      r_led     <= w_led_n;
      r_busy    <= (w_state_n != IDLE);
      r_done    <= (w_state_n == DONE);
      r_aborted <= w_aborted_n;
    end
  end

  assign busy     = r_busy;
  assign led      = r_led;
  assign ch_idx   = r_ch;
  assign dose_cnt = r_cnt;
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule

// File: doc/disp_sequencer.md
Name: disp_sequencer

Overview:
- Parametrised successor to the single-ingredient dispenser stages of the drink machine.
- One block sequences N_CH ingredient channels in fixed order (ch0 first), dispensing a per-drink dose count on each channel.
- Each dose unit is held for TICKS_PER_DOSE clocks; a channel with a dose of zero is skipped.
- Sits between the drink-selection logic, which supplies the dose vector and start, and the ingredient LEDs/valves; done hands off to the serving stage.

Parameters:
- N_CH, 4, number of ingredient channels (>=2).
- DOSE_W, 3, width of each channel's dose count; max dose 2^DOSE_W-1.
- TICKS_PER_DOSE, 2, clock cycles per dose unit (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a drink; sampled only in IDLE.
- doses  in  N_CH*DOSE_W  packed dose counts; channel i at bits [i*DOSE_W +: DOSE_W]; latched on accepted start.
- abort  in  1  cancel the current drink.
- busy  out  1  high in any state other than IDLE.
- led  out  N_CH  one-hot active-channel indicator; all zero when nothing is dispensing.
- ch_idx  out  $clog2(N_CH)  current channel index.
- dose_cnt  out  DOSE_W  dose units completed on the current channel.
- done  out  1  one-cycle pulse when the drink completes.
- aborted  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy, led, ch_idx, dose_cnt, done, aborted all 0.
  - Latched doses and tick counter cleared.
  - Applies immediately, mid-drink included; no done or aborted pulse is produced.
- All outputs are registered and derived from the state registers.
- IDLE:
  - start=1 at an edge latches doses into doses_q and sets ch_idx=0, dose_cnt=0, next state SCAN.
  - start is ignored outside IDLE.
- SCAN (1 cycle, led=0):
  - doses_q[ch_idx]!=0 -> DISPENSE with tick=0, dose_cnt=0.
  - Dose zero and ch_idx==N_CH-1 -> DONE.
  - Dose zero otherwise -> ch_idx+1, stay in SCAN.
- DISPENSE:
  - led[ch_idx]=1.
  - tick counts 0..TICKS_PER_DOSE-1; at the terminal tick, dose_cnt increments.
  - If dose_cnt+1==doses_q[ch_idx]: ch_idx==N_CH-1 -> DONE, else ch_idx+1 -> SCAN.
  - LED high exactly dose*TICKS_PER_DOSE cycles per channel.
  - dose_cnt resets to 0 on entering SCAN.
- DONE (1 cycle):
  - done=1, led=0, next state IDLE.
  - A new start is accepted in IDLE, one cycle later at the earliest.
- abort=1 in SCAN or DISPENSE:
  - Next state IDLE; led cleared at the same edge; aborted=1 for that cycle.
  - No done pulse.
  - abort takes priority over a channel or dose completion in the same cycle.
  - abort in IDLE or DONE is ignored; DONE still completes.
- Widths: dose comparison is done at DOSE_W; the tick counter is $clog2(TICKS_PER_DOSE+1) wide with no wrap.
- Max dose: 2^DOSE_W-1 units, with no overflow of dose_cnt.
- doses changing after acceptance has no effect.

Optional Feature:
- Macro: DISP_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit), e.g. for cup removed.
  - While pause=1 in DISPENSE, tick, dose_cnt and ch_idx hold and led is forced to 0; the dose resumes from the held tick when pause=0.
  - pause has no effect in other states.
  - abort overrides pause.
- Undefined: no pause port; dispensing is never stalled.

Decomposition:
- Package disp_pkg holds:
  - typedef enum logic [2:0] disp_state_t {IDLE, SCAN, DISPENSE, DONE}.
  - Default constants DISP_N_CH=4, DISP_DOSE_W=3, DISP_TICKS=2.
- Sub-module dose_timer, parametrised by TICKS_PER_DOSE:
  - Inputs clk, rst, clear, run.
  - Output dose_tick, a one-cycle pulse at the terminal tick.
  - Instantiated once, with run gated by DISPENSE (and !pause).

Test Plan (N_CH=4, DOSE_W=3, TICKS_PER_DOSE=2):
- Mixed doses {ch0=2,ch1=0,ch2=1,ch3=3}, start pulsed at edge E0:
  - led[0] high 4 cycles, led[1] never, led[2] high 2 cycles, led[3] high 6 cycles.
  - done pulse is the state after E16.
  - busy is high from after E0 through DONE.
- All doses zero, start at E0 -> SCAN for 4 cycles, done after E4, led stays 0.
- abort during the 2nd dose of ch3 -> led=0 and aborted=1 next cycle, no done, busy=0; a following start is accepted normally.
- Second start during DISPENSE with different doses -> ignored; the sequence matches the first vector.
- rst asserted mid-DISPENSE (asynchronous, between edges) -> all outputs 0 immediately; after release, IDLE awaits start.
- DISP_PAUSE_EN: pause 3 cycles during a ch0 dose of 2 -> led[0] total high time still 4 cycles, done delayed exactly 3 cycles.
